// File: rtl/axi4_arb_pkg.sv
// Shared types and constants for the N-requester AXI4 access arbiter.
// Holds the FSM state encodings, the packed control-field offsets and the requester limit.
package axi4_arb_pkg;

   localparam int MAX_REQ  = 8;
   localparam int IDX_W    = $clog2(MAX_REQ);

   localparam int MASK_LSB = 0;
   localparam int SIZE_LSB = 4;
   localparam int LEN_LSB  = 8;
   localparam int LEN_W    = 8;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_BUSY = 1'b1
   } rd_state_e;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_BUSY = 1'b1
   } wr_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: fixed priority (lowest index) or round-robin
// starting one past the last granted index.
module rr_pick
   import axi4_arb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_idx_i,
   input  logic             rr_en_i,
   output logic [N-1:0]     onehot_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [MAX_REQ-1:0] req_pad;
   logic               found;
   int                 pos;

   // Padding to MAX_REQ lets a full-width index address the request vector.
   assign req_pad = MAX_REQ'(req_i);

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      found    = 1'b0;
      idx_o    = '0;
      pos      = 0;
      onehot_o = '0;
      for (int k = 0; k < N; k++) begin
         pos = rr_en_i ? (int'(last_idx_i) + 1 + k) % N : k;
         if (!found && req_pad[IDX_W'(pos)]) begin
            found = 1'b1;
            idx_o = IDX_W'(pos);
         end
      end
      for (int i = 0; i < N; i++) begin
         onehot_o[i] = found && (idx_o == IDX_W'(i));
      end
   end

endmodule

// File: rtl/axi4_arb_rr.sv
// N-requester AXI4 access arbiter with independent read/write channels,
// fixed-priority or round-robin selection, and write-beat counting.
module axi4_arb_rr
   import axi4_arb_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_REQ = 3,
   parameter int RR_MODE = 1,
   parameter int CTRL_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ*XLEN-1:0]   req_raddr_i,
   input  logic [NUM_REQ*CTRL_W-1:0] req_rctrl_i,
   input  logic [NUM_REQ-1:0]        req_rvalid_i,
   output logic [NUM_REQ*XLEN-1:0]   req_rdata_o,
   output logic [NUM_REQ-1:0]        req_rready_o,
   output logic [NUM_REQ-1:0]        req_rlast_o,
   input  logic [NUM_REQ*XLEN-1:0]   req_waddr_i,
   input  logic [NUM_REQ*CTRL_W-1:0] req_wctrl_i,
   input  logic [NUM_REQ*XLEN-1:0]   req_wdata_i,
   input  logic [NUM_REQ-1:0]        req_wvalid_i,
   output logic [NUM_REQ-1:0]        req_wready_o,
   output logic [NUM_REQ-1:0]        rd_grant_o,
   output logic [NUM_REQ-1:0]        wr_grant_o,
   output logic [XLEN-1:0]           arb_raddr_o,
   output logic [CTRL_W-1:0]         arb_rctrl_o,
   output logic                      arb_rvalid_o,
   input  logic [XLEN-1:0]           arb_rdata_i,
   input  logic                      arb_rready_i,
   input  logic                      arb_rlast_i,
   output logic [XLEN-1:0]           arb_waddr_o,
   output logic [CTRL_W-1:0]         arb_wctrl_o,
   output logic [XLEN-1:0]           arb_wdata_o,
   output logic                      arb_wvalid_o,
   output logic                      arb_wlast_o,
   input  logic                      arb_wready_i
);

   localparam logic RR_EN = (RR_MODE != 0);

   logic [XLEN-1:0]   raddr_a [MAX_REQ];
   logic [CTRL_W-1:0] rctrl_a [MAX_REQ];
   logic [XLEN-1:0]   waddr_a [MAX_REQ];
   logic [CTRL_W-1:0] wctrl_a [MAX_REQ];
   logic [XLEN-1:0]   wdata_a [MAX_REQ];

   for (genvar g = 0; g < MAX_REQ; g++) begin : g_unpack
      if (g < NUM_REQ) begin : g_req
         assign raddr_a[g] = req_raddr_i[g*XLEN +: XLEN];
         assign rctrl_a[g] = req_rctrl_i[g*CTRL_W +: CTRL_W];
         assign waddr_a[g] = req_waddr_i[g*XLEN +: XLEN];
         assign wctrl_a[g] = req_wctrl_i[g*CTRL_W +: CTRL_W];
         assign wdata_a[g] = req_wdata_i[g*XLEN +: XLEN];
      end else begin : g_pad
         assign raddr_a[g] = '0;
         assign rctrl_a[g] = '0;
         assign waddr_a[g] = '0;
         assign wctrl_a[g] = '0;
         assign wdata_a[g] = '0;
      end
   end

   rd_state_e          rd_state_q, rd_state_d;
   logic [NUM_REQ-1:0] rd_grant_q, rd_grant_d;
   logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [XLEN-1:0]    arb_raddr_q, arb_raddr_d;
   logic [CTRL_W-1:0]  arb_rctrl_q, arb_rctrl_d;
   logic               arb_rvalid_q, arb_rvalid_d;

   wr_state_e          wr_state_q, wr_state_d;
   logic [NUM_REQ-1:0] wr_grant_q, wr_grant_d;
   logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [XLEN-1:0]    arb_waddr_q, arb_waddr_d;
   logic [CTRL_W-1:0]  arb_wctrl_q, arb_wctrl_d;
   logic               arb_wvalid_q, arb_wvalid_d;
   logic [LEN_W-1:0]   wr_cnt_q, wr_cnt_d;

   logic [NUM_REQ-1:0] rd_pick_oh, wr_pick_oh;
   logic [IDX_W-1:0]   rd_pick_idx, wr_pick_idx;
   logic               wr_busy, wr_last;

   rr_pick #(.N(NUM_REQ)) u_rd_pick (
      .req_i      (req_rvalid_i),
      .last_idx_i (rd_ptr_q),
      .rr_en_i    (RR_EN),
      .onehot_o   (rd_pick_oh),
      .idx_o      (rd_pick_idx)
   );

   rr_pick #(.N(NUM_REQ)) u_wr_pick (
      .req_i      (req_wvalid_i),
      .last_idx_i (wr_ptr_q),
      .rr_en_i    (RR_EN),
      .onehot_o   (wr_pick_oh),
      .idx_o      (wr_pick_idx)
   );

   always_comb begin
      rd_state_d   = rd_state_q;
      rd_grant_d   = rd_grant_q;
      rd_ptr_d     = rd_ptr_q;
      arb_raddr_d  = arb_raddr_q;
      arb_rctrl_d  = arb_rctrl_q;
      arb_rvalid_d = arb_rvalid_q;
      case (rd_state_q)
         RD_IDLE: if (|req_rvalid_i) begin
            rd_state_d   = RD_BUSY;
            rd_grant_d   = rd_pick_oh;
            rd_ptr_d     = rd_pick_idx;
            arb_raddr_d  = raddr_a[rd_pick_idx];
            arb_rctrl_d  = rctrl_a[rd_pick_idx];
            arb_rvalid_d = 1'b1;
         end
         RD_BUSY: if (arb_rready_i && arb_rlast_i) begin
            rd_state_d   = RD_IDLE;
            rd_grant_d   = '0;
            arb_rvalid_d = 1'b0;
         end
      endcase
   end

   assign wr_busy = (wr_state_q == WR_BUSY);
   assign wr_last = wr_busy && (wr_cnt_q == arb_wctrl_q[LEN_LSB +: LEN_W]);

   always_comb begin
      wr_state_d   = wr_state_q;
      wr_grant_d   = wr_grant_q;
      wr_ptr_d     = wr_ptr_q;
      arb_waddr_d  = arb_waddr_q;
      arb_wctrl_d  = arb_wctrl_q;
      arb_wvalid_d = arb_wvalid_q;
      wr_cnt_d     = wr_cnt_q;
      case (wr_state_q)
         WR_IDLE: if (|req_wvalid_i) begin
            wr_state_d   = WR_BUSY;
            wr_grant_d   = wr_pick_oh;
            wr_ptr_d     = wr_pick_idx;
            arb_waddr_d  = waddr_a[wr_pick_idx];
            arb_wctrl_d  = wctrl_a[wr_pick_idx];
            arb_wvalid_d = 1'b1;
            wr_cnt_d     = '0;
         end
         WR_BUSY: if (arb_wready_i) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_last) begin
               wr_state_d   = WR_IDLE;
               wr_grant_d   = '0;
               arb_wvalid_d = 1'b0;
            end
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state_q   <= RD_IDLE;
         rd_grant_q   <= '0;
         rd_ptr_q     <= IDX_W'(NUM_REQ - 1);
         arb_raddr_q  <= '0;
         arb_rctrl_q  <= '0;
         arb_rvalid_q <= 1'b0;
         wr_state_q   <= WR_IDLE;
         wr_grant_q   <= '0;
         wr_ptr_q     <= IDX_W'(NUM_REQ - 1);
         arb_waddr_q  <= '0;
         arb_wctrl_q  <= '0;
         arb_wvalid_q <= 1'b0;
         wr_cnt_q     <= '0;
      end else begin
         rd_state_q   <= rd_state_d;
         rd_grant_q   <= rd_grant_d;
         rd_ptr_q     <= rd_ptr_d;
         arb_raddr_q  <= arb_raddr_d;
         arb_rctrl_q  <= arb_rctrl_d;
         arb_rvalid_q <= arb_rvalid_d;
         wr_state_q   <= wr_state_d;
         wr_grant_q   <= wr_grant_d;
         wr_ptr_q     <= wr_ptr_d;
         arb_waddr_q  <= arb_waddr_d;
         arb_wctrl_q  <= arb_wctrl_d;
         arb_wvalid_q <= arb_wvalid_d;
         wr_cnt_q     <= wr_cnt_d;
      end
   end

   // Responses reach only the granted requester; everyone else sees zeros.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_route
      assign req_rdata_o[g*XLEN +: XLEN] = rd_grant_q[g] ? arb_rdata_i : '0;
      assign req_rready_o[g]             = rd_grant_q[g] & arb_rready_i;
      assign req_rlast_o[g]              = rd_grant_q[g] & arb_rlast_i;
      assign req_wready_o[g]             = wr_grant_q[g] & arb_wready_i;
   end

   assign rd_grant_o   = rd_grant_q;
   assign wr_grant_o   = wr_grant_q;
   assign arb_raddr_o  = arb_raddr_q;
   assign arb_rctrl_o  = arb_rctrl_q;
   assign arb_rvalid_o = arb_rvalid_q;
   assign arb_waddr_o  = arb_waddr_q;
   assign arb_wctrl_o  = arb_wctrl_q;
   assign arb_wvalid_o = arb_wvalid_q;
   assign arb_wlast_o  = wr_last;
   assign arb_wdata_o  = wr_busy ? wdata_a[wr_ptr_q] : '0;

endmodule

// File: tb/tb_axi4_arb_rr.sv
// Scoreboard bench for axi4_arb_rr: a round-robin instance takes most traffic,
// a fixed-priority instance with its own read handshake covers the fixed policy.
module tb_axi4_arb_rr;

   localparam int XLEN    = 32;
   localparam int NUM_REQ = 3;
   localparam int CTRL_W  = 16;

   typedef struct packed {
      logic [NUM_REQ-1:0] gnt;
      logic [XLEN-1:0]    addr;
      logic [CTRL_W-1:0]  ctrl;
   } gnt_t;

   typedef struct packed {
      logic [NUM_REQ-1:0] oh;
      logic [XLEN-1:0]    data;
      logic               last;
   } beat_t;

   logic                      clk, rst;
   logic [NUM_REQ*XLEN-1:0]   req_raddr, req_waddr, req_wdata;
   logic [NUM_REQ*CTRL_W-1:0] req_rctrl, req_wctrl;
   logic [NUM_REQ-1:0]        req_rvalid, req_wvalid;
   logic [NUM_REQ*XLEN-1:0]   req_rdata_o;
   logic [NUM_REQ-1:0]        req_rready_o, req_rlast_o, req_wready_o;
   logic [NUM_REQ-1:0]        rd_grant_o, wr_grant_o;
   logic [XLEN-1:0]           arb_raddr_o, arb_waddr_o, arb_wdata_o, arb_rdata;
   logic [CTRL_W-1:0]         arb_rctrl_o, arb_wctrl_o;
   logic                      arb_rvalid_o, arb_wvalid_o, arb_wlast_o;
   logic                      arb_rready, arb_rlast, arb_wready;

   logic [NUM_REQ-1:0]        fx_rvalid, fx_wvalid;
   logic                      fx_rready, fx_rlast, fx_wready;
   logic [NUM_REQ*XLEN-1:0]   fx_rdata_o;
   logic [NUM_REQ-1:0]        fx_rready_o, fx_rlast_o, fx_wready_o, fx_rd_grant, fx_wr_grant;
   logic [XLEN-1:0]           fx_raddr_o, fx_waddr_o, fx_wdata_o;
   logic [CTRL_W-1:0]         fx_rctrl_o, fx_wctrl_o;
   logic                      fx_rvalid_o, fx_wvalid_o, fx_wlast_o;

   int n_vec = 0;
   int n_err = 0;

   gnt_t  exp_rg[$], exp_wg[$], exp_fg[$];
   beat_t exp_rb[$], exp_wb[$];

   axi4_arb_rr #(.XLEN(XLEN), .NUM_REQ(NUM_REQ), .RR_MODE(1), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst(rst),
      .req_raddr_i(req_raddr), .req_rctrl_i(req_rctrl), .req_rvalid_i(req_rvalid),
      .req_rdata_o(req_rdata_o), .req_rready_o(req_rready_o), .req_rlast_o(req_rlast_o),
      .req_waddr_i(req_waddr), .req_wctrl_i(req_wctrl), .req_wdata_i(req_wdata),
      .req_wvalid_i(req_wvalid), .req_wready_o(req_wready_o),
      .rd_grant_o(rd_grant_o), .wr_grant_o(wr_grant_o),
      .arb_raddr_o(arb_raddr_o), .arb_rctrl_o(arb_rctrl_o), .arb_rvalid_o(arb_rvalid_o),
      .arb_rdata_i(arb_rdata), .arb_rready_i(arb_rready), .arb_rlast_i(arb_rlast),
      .arb_waddr_o(arb_waddr_o), .arb_wctrl_o(arb_wctrl_o), .arb_wdata_o(arb_wdata_o),
      .arb_wvalid_o(arb_wvalid_o), .arb_wlast_o(arb_wlast_o), .arb_wready_i(arb_wready)
   );

   axi4_arb_rr #(.XLEN(XLEN), .NUM_REQ(NUM_REQ), .RR_MODE(0), .CTRL_W(CTRL_W)) dut_fx (
      .clk(clk), .rst(rst),
      .req_raddr_i(req_raddr), .req_rctrl_i(req_rctrl), .req_rvalid_i(fx_rvalid),
      .req_rdata_o(fx_rdata_o), .req_rready_o(fx_rready_o), .req_rlast_o(fx_rlast_o),
      .req_waddr_i(req_waddr), .req_wctrl_i(req_wctrl), .req_wdata_i(req_wdata),
      .req_wvalid_i(fx_wvalid), .req_wready_o(fx_wready_o),
      .rd_grant_o(fx_rd_grant), .wr_grant_o(fx_wr_grant),
      .arb_raddr_o(fx_raddr_o), .arb_rctrl_o(fx_rctrl_o), .arb_rvalid_o(fx_rvalid_o),
      .arb_rdata_i(arb_rdata), .arb_rready_i(fx_rready), .arb_rlast_i(fx_rlast),
      .arb_waddr_o(fx_waddr_o), .arb_wctrl_o(fx_wctrl_o), .arb_wdata_o(fx_wdata_o),
      .arb_wvalid_o(fx_wvalid_o), .arb_wlast_o(fx_wlast_o), .arb_wready_i(fx_wready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitors ----------------
   logic [NUM_REQ-1:0] prev_rg = '0, prev_wg = '0, prev_fg = '0;

   always @(negedge clk) begin : mon_rd_grant
      gnt_t g;
      if (rd_grant_o != '0 && rd_grant_o != prev_rg) begin
         if (exp_rg.size() == 0) check("rd_grant_unexpected", rd_grant_o, 0);
         else begin
            g = exp_rg.pop_front();
            check("rd_grant", rd_grant_o, g.gnt);
            check("rd_addr", arb_raddr_o, g.addr);
            check("rd_ctrl", arb_rctrl_o, g.ctrl);
         end
      end
      prev_rg <= rd_grant_o;
   end

   always @(negedge clk) begin : mon_wr_grant
      gnt_t g;
      if (wr_grant_o != '0 && wr_grant_o != prev_wg) begin
         if (exp_wg.size() == 0) check("wr_grant_unexpected", wr_grant_o, 0);
         else begin
            g = exp_wg.pop_front();
            check("wr_grant", wr_grant_o, g.gnt);
            check("wr_addr", arb_waddr_o, g.addr);
            check("wr_ctrl", arb_wctrl_o, g.ctrl);
         end
      end
      prev_wg <= wr_grant_o;
   end

   always @(negedge clk) begin : mon_fx_grant
      gnt_t g;
      if (fx_rd_grant != '0 && fx_rd_grant != prev_fg) begin
         if (exp_fg.size() == 0) check("fx_grant_unexpected", fx_rd_grant, 0);
         else begin
            g = exp_fg.pop_front();
            check("fx_grant", fx_rd_grant, g.gnt);
            check("fx_addr", fx_raddr_o, g.addr);
         end
      end
      prev_fg <= fx_rd_grant;
   end

   always @(negedge clk) begin : mon_rd_beat
      beat_t b;
      logic [NUM_REQ*XLEN-1:0] ev;
      if (|req_rready_o) begin
         if (exp_rb.size() == 0) check("rd_beat_unexpected", req_rready_o, 0);
         else begin
            b  = exp_rb.pop_front();
            ev = '0;
            for (int i = 0; i < NUM_REQ; i++) if (b.oh[i]) ev[i*XLEN +: XLEN] = b.data;
            check("rd_ready", req_rready_o, b.oh);
            check("rd_data", req_rdata_o, ev);
            check("rd_last", req_rlast_o, b.last ? b.oh : '0);
         end
      end
   end

   always @(negedge clk) begin : mon_wr_beat
      beat_t b;
      if (|req_wready_o) begin
         if (exp_wb.size() == 0) check("wr_beat_unexpected", req_wready_o, 0);
         else begin
            b = exp_wb.pop_front();
            check("wr_ready", req_wready_o, b.oh);
            check("wr_data", arb_wdata_o, b.data);
            check("wr_last", arb_wlast_o, b.last);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic sel_val(input int sel);
      case (sel)
         0:       return arb_rvalid_o;
         1:       return arb_wvalid_o;
         default: return fx_rvalid_o;
      endcase
   endfunction

   task automatic wait_grant(input int sel, input string name);
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (sel_val(sel)) break;
      end
      check(name, sel_val(sel), 1);
   endtask

   task automatic rd_beat(input logic [XLEN-1:0] data, input logic last);
      arb_rdata = data; arb_rready = 1'b1; arb_rlast = last;
      @(posedge clk); #1;
      arb_rdata = '0; arb_rready = 1'b0; arb_rlast = 1'b0;
   endtask

   task automatic fx_beat();
      fx_rready = 1'b1; fx_rlast = 1'b1;
      @(posedge clk); #1;
      fx_rready = 1'b0; fx_rlast = 1'b0;
   endtask

   task automatic check_idle(input string name);
      @(negedge clk);
      check({name, "_rvalid"}, arb_rvalid_o, 0);
      check({name, "_wvalid"}, arb_wvalid_o, 0);
      check({name, "_grants"}, {rd_grant_o, wr_grant_o}, 0);
      check({name, "_wdata"}, arb_wdata_o, 0);
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   // ---------------- directed stimulus ----------------
   initial begin : stim
      logic [NUM_REQ-1:0] rr_order [6];
      logic [3:0]         pat;
      int                 acc;
      rr_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

      rst = 1'b0;
      req_rvalid = '0; req_wvalid = '0; fx_rvalid = '0; fx_wvalid = '0;
      req_wdata = '0; req_waddr = '0; req_wctrl = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_raddr[i*XLEN +: XLEN]     = 32'h1000 + 32'(i) * 32'h100;
         req_rctrl[i*CTRL_W +: CTRL_W] = 16'h002F;
      end
      arb_rdata = '0; arb_rready = 0; arb_rlast = 0; arb_wready = 0;
      fx_rready = 0; fx_rlast = 0; fx_wready = 0;

      // Reset asserted between clock edges
      #3 rst = 1'b1;
      #1;
      check("rst_grants", {rd_grant_o, wr_grant_o, fx_rd_grant}, 0);
      check("rst_valids", {arb_rvalid_o, arb_wvalid_o, arb_wlast_o}, 0);
      check("rst_raddr_ctrl", {arb_raddr_o, arb_rctrl_o}, 0);
      check("rst_waddr_ctrl", {arb_waddr_o, arb_wctrl_o}, 0);
      check("rst_wdata", arb_wdata_o, 0);
      check("rst_readies", {req_rready_o, req_wready_o, req_rlast_o}, 0);
      #12 rst = 1'b0;
      @(posedge clk); #1;

      // Fixed priority: 110 -> 010, pending 100 after an idle cycle, then 111 twice -> 001, 001
      exp_fg.push_back('{3'b010, 32'h1100, 16'h002F});
      exp_fg.push_back('{3'b100, 32'h1200, 16'h002F});
      exp_fg.push_back('{3'b001, 32'h1000, 16'h002F});
      exp_fg.push_back('{3'b001, 32'h1000, 16'h002F});
      fx_rvalid = 3'b110;
      wait_grant(2, "fx_grant_wait");
      fx_rvalid = 3'b100;
      fx_beat();
      @(negedge clk);
      check("fx_idle_gap", fx_rd_grant, 0);
      wait_grant(2, "fx_grant_wait");
      fx_rvalid = 3'b000;
      fx_beat();
      fx_rvalid = 3'b111;
      wait_grant(2, "fx_grant_wait");
      fx_beat();
      wait_grant(2, "fx_grant_wait");
      fx_rvalid = 3'b000;
      fx_beat();

      // Round robin: all three hold valid for six single-beat reads
      for (int n = 0; n < 6; n++) begin
         exp_rg.push_back('{rr_order[n], 32'h1000 + 32'h100 * ((n % 3)), 16'h002F});
         exp_rb.push_back('{rr_order[n], 32'h5000 + 32'(n), 1'b1});
      end
      req_rvalid = 3'b111;
      for (int n = 0; n < 6; n++) begin
         wait_grant(0, "rr_grant_wait");
         if (n == 5) req_rvalid = 3'b000;
         rd_beat(32'h5000 + 32'(n), 1'b1);
      end
      check_idle("rr_done");

      // Read burst, requester 2, len=3
      req_raddr[2*XLEN +: XLEN]     = 32'h2000;
      req_rctrl[2*CTRL_W +: CTRL_W] = 16'h032F;
      exp_rg.push_back('{3'b100, 32'h2000, 16'h032F});
      for (int k = 0; k < 4; k++) exp_rb.push_back('{3'b100, 32'hA0 + 32'(k), k == 3});
      req_rvalid = 3'b100;
      wait_grant(0, "burst_grant_wait");
      req_rvalid = 3'b000;
      for (int k = 0; k < 4; k++) rd_beat(32'hA0 + 32'(k), k == 3);
      check_idle("burst_done");

      // Write burst, requester 1, len=2, wready pattern 1,0,1,1
      req_waddr[1*XLEN +: XLEN]     = 32'h3000;
      req_wctrl[1*CTRL_W +: CTRL_W] = 16'h022F;
      exp_wg.push_back('{3'b010, 32'h3000, 16'h022F});
      req_wvalid = 3'b010;
      wait_grant(1, "wr_grant_wait");
      req_wvalid = 3'b000;
      pat = 4'b1101;
      acc = 0;
      for (int k = 0; k < 4; k++) begin
         req_wdata[1*XLEN +: XLEN] = 32'hD0 + 32'(k);
         arb_wready = pat[k];
         if (pat[k]) begin
            exp_wb.push_back('{3'b010, 32'hD0 + 32'(k), acc == 2});
            acc++;
         end
         @(negedge clk);
         check("wdata_track", arb_wdata_o, 32'hD0 + 32'(k));
         if (!pat[k]) check("wlast_gap", arb_wlast_o, 0);
         @(posedge clk); #1;
      end
      arb_wready = 1'b0;
      check_idle("wburst_done");

      // Stray bridge handshakes while both channels idle
      arb_wready = 1'b1; arb_rready = 1'b1; arb_rlast = 1'b1; arb_rdata = 32'hDEAD;
      @(negedge clk);
      check("idle_stray_ready", {req_rready_o, req_wready_o, req_rlast_o}, 0);
      check("idle_stray_wlast", arb_wlast_o, 0);
      @(posedge clk); #1;
      arb_wready = 1'b0; arb_rready = 1'b0; arb_rlast = 1'b0; arb_rdata = '0;
      check_idle("stray_done");

      // Concurrent: requester 0 writes (len=0) while requester 1 reads
      req_waddr[0*XLEN +: XLEN]     = 32'h4000;
      req_wctrl[0*CTRL_W +: CTRL_W] = 16'h002F;
      req_wdata[0*XLEN +: XLEN]     = 32'h88;
      req_raddr[1*XLEN +: XLEN]     = 32'h4100;
      exp_wg.push_back('{3'b001, 32'h4000, 16'h002F});
      exp_rg.push_back('{3'b010, 32'h4100, 16'h002F});
      exp_rb.push_back('{3'b010, 32'h77, 1'b1});
      exp_wb.push_back('{3'b001, 32'h88, 1'b1});
      req_wvalid = 3'b001; req_rvalid = 3'b010;
      @(posedge clk); #1;
      req_wvalid = 3'b000; req_rvalid = 3'b000;
      @(negedge clk);
      check("conc_rd_grant", rd_grant_o, 3'b010);
      check("conc_wr_grant", wr_grant_o, 3'b001);
      @(posedge clk); #1;
      rd_beat(32'h77, 1'b1);
      @(negedge clk);
      check("conc_wr_still_busy", arb_wvalid_o, 1);
      @(posedge clk); #1;
      arb_wready = 1'b1;
      @(posedge clk); #1;
      arb_wready = 1'b0;
      check_idle("conc_done");

      // Reset during a len=3 read burst, then index 0 wins again
      req_raddr[0*XLEN +: XLEN]     = 32'h6000;
      req_rctrl[0*CTRL_W +: CTRL_W] = 16'h032F;
      exp_rg.push_back('{3'b001, 32'h6000, 16'h032F});
      exp_rb.push_back('{3'b001, 32'hB0, 1'b0});
      req_rvalid = 3'b001;
      wait_grant(0, "rstbusy_grant_wait");
      req_rvalid = 3'b000;
      rd_beat(32'hB0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("rstbusy_rvalid", arb_rvalid_o, 0);
      check("rstbusy_grant", rd_grant_o, 0);
      check("rstbusy_raddr", {arb_raddr_o, arb_rctrl_o}, 0);
      @(posedge clk); #2 rst = 1'b0;
      req_rctrl[0*CTRL_W +: CTRL_W] = 16'h002F;
      exp_rg.push_back('{3'b001, 32'h6000, 16'h002F});
      exp_rb.push_back('{3'b001, 32'hC0, 1'b1});
      req_rvalid = 3'b101;
      wait_grant(0, "post_rst_grant_wait");
      req_rvalid = 3'b000;
      rd_beat(32'hC0, 1'b1);
      check_idle("post_rst_done");

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rd_grant_queue_left", exp_rg.size(), 0);
      check("wr_grant_queue_left", exp_wg.size(), 0);
      check("fx_grant_queue_left", exp_fg.size(), 0);
      check("rd_beat_queue_left", exp_rb.size(), 0);
      check("wr_beat_queue_left", exp_wb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
